// File: rtl/rect_pkg.sv
// Shared definitions for the rectangle rasterizer: screen geometry defaults,
// coordinate widths, named colours and the request FSM state encoding.
package rect_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int X_W_DEF      = 8;
    localparam int Y_W_DEF      = 7;
    localparam int COLOUR_W_DEF = 3;

    localparam logic [COLOUR_W_DEF-1:0] BACKGROUND_COLOUR = 3'b111;
    localparam logic [COLOUR_W_DEF-1:0] WALL_COLOUR       = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Row-major 2-D offset counter for the rasterizer. xo/yo hold the offset of
// the pixel that will be loaded into the output registers at the next advance;
// last flags that this offset is the bottom-right corner (w-1, h-1).
module rect_scan_counter
    import rect_pkg::*;
#(
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           enable,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] xo,
    output logic [Y_W-1:0] yo,
    output logic           last
);

    localparam logic [X_W-1:0] X_ONE = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

    logic [X_W-1:0] xo_q, xo_d;
    logic [Y_W-1:0] yo_q, yo_d;
    logic           row_end;

    assign row_end = (xo_q == w - X_ONE);
    assign last    = row_end && (yo_q == h - Y_ONE);
    assign xo      = xo_q;
    assign yo      = yo_q;

    // Next offset: wrap to the start of the next row at the right edge.
    always_comb begin
        xo_d = xo_q;
        yo_d = yo_q;
        if (clear) begin
            xo_d = '0;
            yo_d = '0;
        end else if (enable) begin
            if (row_end) begin
                xo_d = '0;
                yo_d = yo_q + Y_ONE;
            end else begin
                xo_d = xo_q + X_ONE;
            end
        end
    end

    // Offset registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xo_q <= '0;
            yo_q <= '0;
        end else begin
            xo_q <= xo_d;
            yo_q <= yo_d;
        end
    end

endmodule

// File: rtl/rect_rasterizer.sv
// Rectangle drawing engine: accepts one origin/size/colour request, walks the
// area row-major at one pixel per clock towards the VGA adapter, clips pixels
// that fall off-screen (they still take their cycle), then pulses done.
module rect_rasterizer
    import rect_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int COLOUR_W = COLOUR_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      start_x,
    input  logic [Y_W-1:0]      start_y,
    input  logic [X_W-1:0]      width,
    input  logic [Y_W-1:0]      height,
    input  logic [COLOUR_W-1:0] colour,
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot
);

    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

    state_t              state_q;
    logic                busy_q, done_q, plot_q, final_q;
    logic [X_W-1:0]      x_q, sx_q, w_q;
    logic [Y_W-1:0]      y_q, sy_q, h_q;
    logic [COLOUR_W-1:0] col_q, c_q;

    logic                idle, scan;
    logic [X_W-1:0]      base_x, w_sel, xo;
    logic [Y_W-1:0]      base_y, h_sel, yo;
    logic [X_W:0]        px_sum;
    logic [Y_W:0]        py_sum;
    logic [X_W-1:0]      x_d;
    logic [Y_W-1:0]      y_d;
    logic                plot_d, cnt_clear, cnt_en, cnt_last;

    function automatic logic on_screen(input logic [X_W:0] px, input logic [Y_W:0] py);
        return (px < X_LIM) && (py < Y_LIM);
    endfunction

    assign busy       = busy_q;
    assign done       = done_q;
    assign plot       = plot_q;
    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour_out = col_q;

    // In IDLE the counter sits at (0,0) and the live request size drives its
    // first advance, so pixel 0 can be registered on the accepting edge.
    rect_scan_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .w      (w_sel),
        .h      (h_sel),
        .xo     (xo),
        .yo     (yo),
        .last   (cnt_last)
    );

    // Pixel address for the next output load, plus counter control.
    always_comb begin
        idle      = (state_q == ST_IDLE);
        scan      = (state_q == ST_SCAN);
        base_x    = idle ? start_x : sx_q;
        base_y    = idle ? start_y : sy_q;
        w_sel     = idle ? width   : w_q;
        h_sel     = idle ? height  : h_q;
        px_sum    = {1'b0, base_x} + {1'b0, xo};
        py_sum    = {1'b0, base_y} + {1'b0, yo};
        x_d       = px_sum[X_W-1:0];
        y_d       = py_sum[Y_W-1:0];
        plot_d    = on_screen(px_sum, py_sum);
        cnt_clear = (state_q == ST_DONE) || (idle && !start);
        cnt_en    = (idle && start) || (scan && !final_q);
    end

    // Request FSM with registered adapter outputs; final_q marks that the
    // pixel currently on the outputs is the last one of the rectangle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            plot_q  <= 1'b0;
            final_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            c_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    plot_q <= 1'b0;
                    if (start) begin
                        sx_q   <= start_x;
                        sy_q   <= start_y;
                        w_q    <= width;
                        h_q    <= height;
                        c_q    <= colour;
                        busy_q <= 1'b1;
                        if (width != '0 && height != '0) begin
                            state_q <= ST_SCAN;
                            x_q     <= x_d;
                            y_q     <= y_d;
                            col_q   <= colour;
                            plot_q  <= plot_d;
                            final_q <= cnt_last;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (final_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        plot_q  <= 1'b0;
                        final_q <= 1'b0;
                    end else begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        col_q   <= c_q;
                        plot_q  <= plot_d;
                        final_q <= cnt_last;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    plot_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_rasterizer.sv
// Testbench for rect_rasterizer: a queue-based pixel-list model predicts every
// cycle's outputs; directed requests pin the model with literal expectations,
// followed by randomized requests with mid-scan start glitches.
module tb_rect_rasterizer;
    import rect_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_x = '0;
    logic [6:0] start_y = '0;
    logic [7:0] width = '0;
    logic [6:0] height = '0;
    logic [2:0] colour = '0;
    logic       busy, done, plot;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;

    always #5 clk = ~clk;

    rect_rasterizer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_x    (start_x),
        .start_y    (start_y),
        .width      (width),
        .height     (height),
        .colour     (colour),
        .busy       (busy),
        .done       (done),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot)
    );

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endfunction

    // ---------------- behavioural model ----------------
    localparam int K_RST = 0, K_IDLE = 1, K_PIX = 2, K_DONE = 3;
    typedef struct {
        int kind;
        int x;
        int y;
        int c;
        int p;
    } exp_t;

    exp_t q[$];
    exp_t cur = '{K_RST, 0, 0, 0, 0};
    int   build_len = 0;
    int   build_plots = 0;

    function automatic exp_t mk(input int k, input int x, input int y, input int c, input int p);
        exp_t e;
        e.kind = k; e.x = x; e.y = y; e.c = c; e.p = p;
        return e;
    endfunction

    // Expected cycle list of one request: every pixel row-major, then done.
    function automatic void build(input int sx, input int sy, input int w, input int h, input int c);
        build_len = 0;
        build_plots = 0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                int px, py, p;
                px = sx + xx;
                py = sy + yy;
                p  = (px < 160 && py < 120) ? 1 : 0;
                q.push_back(mk(K_PIX, px % 256, py % 128, c, p));
                build_len++;
                build_plots += p;
            end
        end
        q.push_back(mk(K_DONE, 0, 0, 0, 0));
        build_len++;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            cur = mk(K_RST, 0, 0, 0, 0);
        end else begin
            if ((cur.kind == K_IDLE || cur.kind == K_RST) && start)
                build(int'(start_x), int'(start_y), int'(width), int'(height), int'(colour));
            if (q.size() > 0) cur = q.pop_front();
            else cur = mk(K_IDLE, 0, 0, 0, 0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        case (cur.kind)
            K_RST:  chk("reset_outputs", longint'({busy, done, plot, x_out, y_out, colour_out}), 0);
            K_IDLE: chk("idle_ctl", longint'({busy, done, plot}), 0);
            K_PIX:  chk("pixel", longint'({busy, done, plot, x_out, y_out, colour_out}),
                        longint'((1 << 20) | (cur.p << 18) | (cur.x << 10) | (cur.y << 3) | cur.c));
            default: chk("done_ctl", longint'({busy, done, plot}), 6);
        endcase
    end

    // ---------------- directed helpers ----------------
    int px_log[0:4095];
    int py_log[0:4095];
    int done_cyc, plots, scans;

    task automatic run_req(input int sx, input int sy, input int w, input int h, input int c, input bit glitch);
        int cyc;
        bit fin;
        @(negedge clk);
        start_x = 8'(sx); start_y = 7'(sy); width = 8'(w); height = 7'(h); colour = 3'(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; fin = 1'b0; plots = 0; scans = 0; done_cyc = -1;
        while (!fin && cyc < 5000) begin
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end else begin
                if (busy) begin
                    if (scans < 4096) begin
                        px_log[scans] = int'(x_out);
                        py_log[scans] = int'(y_out);
                    end
                    scans++;
                    if (plot) plots++;
                end
                if (glitch && cyc == 2) begin
                    start = 1'b1;
                    start_x = 8'($urandom); start_y = 7'($urandom);
                    width = 8'($urandom); height = 7'($urandom); colour = 3'($urandom);
                end else begin
                    start = 1'b0;
                end
                cyc++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!fin) chk("request_timeout", 0, 1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk(name, 0, 1);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_hold", longint'({busy, done, plot, x_out, y_out, colour_out}), 0);
        #2 reset = 1'b0;

        // reset in the middle of a scan, then held
        @(negedge clk);
        start_x = 8'd20; start_y = 7'd5; width = 8'd20; height = 7'd5; colour = 3'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midscan_busy", longint'({busy, plot}), 3);
        #2 reset = 1'b1;
        #1 chk("reset_mid_outputs", longint'({busy, done, plot, x_out, y_out, colour_out}), 0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_held_outputs", longint'({busy, done, plot, x_out, y_out, colour_out}), 0);
        end
        #2 reset = 1'b0;

        // tall wall column
        run_req(100, 0, 10, 120, int'(WALL_COLOUR), 1'b0);
        chk("wall_done_cycle", done_cyc, 1201);
        chk("wall_plots", plots, 1200);
        chk("wall_scan_cycles", scans, 1200);
        chk("wall_px1", longint'((px_log[0] << 8) | py_log[0]), (100 << 8) | 0);
        chk("wall_px10", longint'((px_log[9] << 8) | py_log[9]), (109 << 8) | 0);
        chk("wall_px11", longint'((px_log[10] << 8) | py_log[10]), (100 << 8) | 1);
        chk("wall_px_last", longint'((px_log[1199] << 8) | py_log[1199]), (109 << 8) | 119);
        chk("model_wall_len", build_len, 1201);
        chk("model_wall_plots", build_plots, 1200);

        // empty requests
        run_req(10, 10, 0, 5, 1, 1'b0);
        chk("empty_w_done_cycle", done_cyc, 1);
        chk("empty_w_plots", plots + scans, 0);
        run_req(10, 10, 5, 0, 1, 1'b0);
        chk("empty_h_done_cycle", done_cyc, 1);
        chk("empty_h_plots", plots + scans, 0);

        // bottom-right corner clipping
        run_req(155, 118, 10, 4, int'(BACKGROUND_COLOUR), 1'b0);
        chk("clip_done_cycle", done_cyc, 41);
        chk("clip_scan_cycles", scans, 40);
        chk("clip_plots", plots, 10);
        chk("clip_x5", px_log[4], 159);
        chk("clip_x6_truncated", px_log[5], 160);
        chk("model_clip_plots", build_plots, 10);

        // start pulsed mid-scan with other values
        run_req(30, 40, 6, 5, 5, 1'b1);
        chk("glitch_done_cycle", done_cyc, 31);
        chk("glitch_plots", plots, 30);
        chk("glitch_last_px", longint'((px_log[29] << 8) | py_log[29]), (35 << 8) | 44);

        // start held high through done
        @(negedge clk);
        start_x = 8'd3; start_y = 7'd4; width = 8'd1; height = 7'd1; colour = 3'd6;
        start = 1'b1;
        @(negedge clk);
        wait_done("held_first_timeout");
        @(negedge clk);
        chk("held_gap_idle", longint'({busy, done, plot}), 0);
        @(negedge clk);
        chk("held_second_pixel", longint'({busy, plot, x_out, y_out, colour_out}),
            longint'((1 << 19) | (1 << 18) | (3 << 10) | (4 << 3) | 6));
        start = 1'b0;
        wait_done("held_second_timeout");

        // reset at pixel 50 of a 10x10 draw
        @(negedge clk);
        start_x = 8'd20; start_y = 7'd20; width = 8'd10; height = 7'd10; colour = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        chk("px50_position", longint'({busy, x_out, y_out}), longint'((1 << 15) | (29 << 7) | 24));
        #2 reset = 1'b1;
        #1 chk("px50_reset_outputs", longint'({busy, done, plot, x_out, y_out, colour_out}), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("no_done_after_reset", cnt, 0);
        run_req(0, 0, 2, 2, 3, 1'b0);
        chk("after_reset_done_cycle", done_cyc, 5);
        chk("after_reset_plots", plots, 4);

        // randomized requests
        for (int i = 0; i < 40; i++) begin
            int w, h;
            w = int'($urandom_range(0, 20));
            h = int'($urandom_range(0, 12));
            run_req(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), w, h,
                    int'($urandom_range(0, 7)), (w * h >= 3) && ($urandom_range(0, 1) == 1));
            chk("rand_done_cycle", done_cyc, w * h + 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
